wb_sram_bridge: RTL
===================

WB_SRAM_BRIDGE -- requirements
Module: wb_sram_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, 32'h3000_0000, Wishbone window base; bits [31:13] compared, [12:0] ignored.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 8'd64, WAIT-state cycle limit (used only with REQ-030), legal 1..255.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the ports are listed first, as follows.
REQ-004 wb_clk_i  in  1  sole clock, all state on rising edge.
REQ-005 wb_rst_ni  in  1  asynchronous active-low reset.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
REQ-007 wbs_sel_i  in  4  byte selects; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-008 wbs_ack_o  out  1  transfer acknowledge; wbs_dat_o  out  32  read data.
REQ-009 mem_addr_o  out  11  word address to downstream SRAM mux (bit 10 selects bank B).
REQ-010 mem_be_o  out  4; mem_wdata_o  out  32; mem_we_o  out  1; mem_stb_o, mem_cyc_o  out  1 each.
REQ-011 mem_rdata_i  in  32; mem_rvalid_i  in  1  response from selected bank, for reads and writes.
REQ-012 timeout_o  out  1  sticky timeout flag.

Function
REQ-013 hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:13] == BASE_ADDR[31:13]); misses never acknowledged, never forwarded.
REQ-014 FSM states IDLE, REQ, WAIT, ACK; encoding free.
REQ-015 IDLE: on hit, register mem_addr_o = wbs_adr_i[12:2], mem_be_o = wbs_sel_i, mem_wdata_o = wbs_dat_i, mem_we_o = wbs_we_i; go REQ.
REQ-016 REQ: mem_stb_o = mem_cyc_o = 1 for exactly this one cycle; all other states drive them 0.
REQ-017 mem_rvalid_i SHALL be sampled in REQ and WAIT; REQ with rvalid=1 -> ACK, else -> WAIT; WAIT holds until rvalid=1 -> ACK.
REQ-018 On the sampled rvalid, capture mem_rdata_i for reads, 32'h0 for writes.
REQ-019 ACK: wbs_ack_o = 1 for exactly one cycle with wbs_dat_o = captured data; next state IDLE.
REQ-020 Minimum latency: hit at cycle T, rvalid at T+2 -> wbs_ack_o at T+3; rvalid at T+1 (in REQ) -> ack at T+2.
REQ-021 Back-to-back: a new hit in the IDLE cycle following ACK SHALL be accepted with no bubble.
REQ-022 mem_addr/be/wdata/we SHALL hold stable from REQ through ACK.
REQ-023 Master abort (wbs_cyc_i=0 in REQ or WAIT): still wait for rvalid, suppress wbs_ack_o, return IDLE.
REQ-024 mem_rvalid_i in IDLE or ACK SHALL be ignored.
REQ-025 wbs_ack_o SHALL never assert unless cyc & stb were high on the accepting cycle; wbs_dat_o = 0 outside ACK.

Reset
REQ-026 Reset asserts asynchronously; state -> IDLE, all outputs and registers 0, including timeout_o.
REQ-027 Reset mid-transaction SHALL abort without ack; any later rvalid for it is ignored per REQ-024.
REQ-028 Deassertion is synchronous to wb_clk_i; first hit accepted on the first rising edge with wb_rst_ni=1.

Configuration
REQ-029 Macro WB_SRAM_TIMEOUT_EN selects the WAIT timeout.
REQ-030 Defined: 8-bit counter cleared entering WAIT, +1 per WAIT cycle; when it equals TIMEOUT_CYCLES without rvalid -> ACK with wbs_dat_o = 32'hDEAD_BEEF, set timeout_o (cleared only by reset).
REQ-031 Not defined: no counter, WAIT waits indefinitely, timeout_o tied 0.

Verification
REQ-032 Read: wbs_adr_i=32'h3000_0010, we=0, rvalid+rdata=32'hCAFE_F00D at T+2 -> mem_addr_o=11'h004, ack at T+3, wbs_dat_o=32'hCAFE_F00D.
REQ-033 Write bank B: adr=32'h3000_1008, sel=4'b0011, dat=32'h1234_5678 -> mem_addr_o=11'h402, mem_be_o=4'b0011, mem_we_o=1, single-cycle mem_stb_o, ack with wbs_dat_o=0.
REQ-034 Miss: adr=32'h3000_2000 held 20 cycles -> mem_stb_o and wbs_ack_o stay 0.
REQ-035 Abort: cyc dropped at T+1, rvalid at T+4 -> no ack, IDLE at T+5, next hit accepted normally.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES=4): no rvalid -> ack with 32'hDEAD_BEEF, timeout_o=1 until reset; macro off -> no ack.
REQ-037 Reset in WAIT, then rvalid -> no ack, all outputs 0 asynchronously.

Source files
------------

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave to single-port SRAM mux bridge.
// One outstanding transfer: IDLE -> REQ -> (WAIT) -> ACK -> IDLE.
// Optional WAIT-state timeout enabled by defining WB_SRAM_TIMEOUT_EN.
module wb_sram_bridge #(
   parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
   parameter logic [7:0]  TIMEOUT_CYCLES = 8'd64
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [10:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_we_o,
   output logic        mem_stb_o,
   output logic        mem_cyc_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_rvalid_i,
   output logic        timeout_o
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StAck} state_e;

   state_e      state_q, state_d;
   logic [10:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [31:0] rdata_q, rdata_d;
   logic        abort_q, abort_d;
   logic        hit;
   logic        unused_bits;

   assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:13] == BASE_ADDR[31:13]);
   assign unused_bits = ^{wbs_adr_i[1:0], TIMEOUT_CYCLES};

`ifdef WB_SRAM_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       timeout_q, timeout_d;
`endif

   // Next-state logic: capture request, wait for the bank response, acknowledge.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      abort_d = abort_q;
`ifdef WB_SRAM_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (hit) begin
               state_d = StReq;
               addr_d  = wbs_adr_i[12:2];
               be_d    = wbs_sel_i;
               wdata_d = wbs_dat_i;
               we_d    = wbs_we_i;
               abort_d = 1'b0;
            end
         end
         StReq, StWait: begin
            // A dropped cycle still has to drain the bank response, just without ack.
            if (!wbs_cyc_i) begin
               abort_d = 1'b1;
            end
`ifdef WB_SRAM_TIMEOUT_EN
            cnt_d = (state_q == StReq) ? 8'd0 : cnt_q + 8'd1;
`endif
            if (mem_rvalid_i) begin
               rdata_d = we_q ? 32'h0 : mem_rdata_i;
               state_d = abort_d ? StIdle : StAck;
            end else if (state_q == StReq) begin
               state_d = StWait;
            end
`ifdef WB_SRAM_TIMEOUT_EN
            else if (cnt_d == TIMEOUT_CYCLES) begin
               rdata_d   = 32'hDEAD_BEEF;
               timeout_d = 1'b1;
               state_d   = abort_d ? StIdle : StAck;
            end
`endif
         end
         StAck: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and transaction registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= StIdle;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         abort_q <= abort_d;
      end
   end

`ifdef WB_SRAM_TIMEOUT_EN
   // WAIT-cycle counter and sticky timeout flag.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   assign wbs_ack_o   = (state_q == StAck);
   assign wbs_dat_o   = (state_q == StAck) ? rdata_q : 32'h0;
   assign mem_stb_o   = (state_q == StReq);
   assign mem_cyc_o   = (state_q == StReq);
   assign mem_addr_o  = addr_q;
   assign mem_be_o    = be_q;
   assign mem_wdata_o = wdata_q;
   assign mem_we_o    = we_q;

endmodule
